mem_run_sequencer: RTL and testbench

Top-level run controller for the processor core. It drives the core's `status` mode bus and its external data-memory port (`data_in`, `data_addr_in`) through a fixed job sequence:
- load a byte stream into data memory (status 10);
- release the core to execute (status 01) until `end_process`;
- read a result window back out of data memory (status 11) to a byte-stream consumer.

It sits between the host byte interface and the processor/data-memory pair.

---
 rtl/mem_run_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mem_run_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_run_sequencer.sv
// Job sequencer: loads bytes into data memory, runs the core, then streams a result window back.
// All outputs are registered; next-state values are computed in one combinational block.
module mem_run_sequencer #(
  parameter logic [15:0] LOAD_BASE  = 16'h0000,
  parameter logic [15:0] LOAD_COUNT = 16'd256,
  parameter logic [15:0] READ_BASE  = 16'h0000,
  parameter logic [15:0] READ_COUNT = 16'd256,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MIN_RUN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        end_process,
  input  logic [7:0]  dm_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [1:0]  status,
  output logic [7:0]  data_in,
  output logic [15:0] data_addr_in,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  STATUS_HOLD  = 2'b00;
  localparam logic [1:0]  STATUS_RUN   = 2'b01;
  localparam logic [1:0]  STATUS_WRITE = 2'b10;
  localparam logic [1:0]  STATUS_READ  = 2'b11;
  localparam logic [15:0] RD_LAT_W     = 16'(RD_LAT);
  localparam logic [15:0] MIN_RUN_W    = 16'(MIN_RUN);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRun, StRdAddr, StRdWait, StRdSend, StDone
  } state_e;

  state_e      r_state, w_state;
  logic [15:0] r_idx, w_idx;
  logic [15:0] r_wait, w_wait;
  logic [15:0] r_run_cnt, w_run_cnt;
  logic [1:0]  r_status, w_status;
  logic [7:0]  r_data_in, w_data_in;
  logic [15:0] r_addr, w_addr;
  logic        r_rx_ready, w_rx_ready;
  logic        r_tx_valid, w_tx_valid;
  logic [7:0]  r_tx_data, w_tx_data;
  logic        r_busy, w_busy;
  logic        r_done, w_done;

  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_wait     = r_wait;
    w_run_cnt  = r_run_cnt;
    w_status   = r_status;
    w_data_in  = r_data_in;
    w_addr     = r_addr;
    w_rx_ready = r_rx_ready;
    w_tx_valid = r_tx_valid;
    w_tx_data  = r_tx_data;
    w_busy     = r_busy;
    w_done     = 1'b0;

    case (r_state)
      StIdle: begin
        w_status = STATUS_HOLD;
        if (start) begin
          w_state    = StLoad;
          w_idx      = 16'd0;
          w_rx_ready = 1'b1;
          w_busy     = 1'b1;
        end
      end
      StLoad: begin
        w_status = STATUS_HOLD;
        // rx_ready low here means the final write has just been issued
        if (!r_rx_ready) begin
          w_state   = StRun;
          w_status  = STATUS_RUN;
          w_run_cnt = 16'd0;
        end else if (rx_valid) begin
          w_status  = STATUS_WRITE;
          w_data_in = rx_data;
          w_addr    = LOAD_BASE + r_idx;
          w_idx     = r_idx + 16'd1;
          if (r_idx == LOAD_COUNT - 16'd1) begin
            w_rx_ready = 1'b0;
          end
        end
      end
      StRun: begin
        w_status = STATUS_RUN;
        if (r_run_cnt < MIN_RUN_W) begin
          w_run_cnt = r_run_cnt + 16'd1;
        end else if (end_process) begin
          w_state  = StRdAddr;
          w_idx    = 16'd0;
          w_status = STATUS_READ;
          w_addr   = READ_BASE;
        end
      end
      StRdAddr: begin
        w_wait  = RD_LAT_W;
        w_state = StRdWait;
      end
      StRdWait: begin
        w_wait = r_wait - 16'd1;
        if (r_wait == 16'd1) begin
          w_tx_data  = dm_out;
          w_tx_valid = 1'b1;
          w_state    = StRdSend;
        end
      end
      StRdSend: begin
        if (tx_ready) begin
          w_tx_valid = 1'b0;
          w_idx      = r_idx + 16'd1;
          if (r_idx == READ_COUNT - 16'd1) begin
            w_state  = StDone;
            w_status = STATUS_HOLD;
            w_done   = 1'b1;
          end else begin
            // address goes out on entry to RD_ADDR so the wait covers the full latency
            w_state = StRdAddr;
            w_addr  = READ_BASE + r_idx + 16'd1;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= 16'd0;
      r_wait     <= 16'd0;
      r_run_cnt  <= 16'd0;
      r_status   <= STATUS_HOLD;
      r_data_in  <= 8'd0;
      r_addr     <= 16'd0;
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_wait     <= w_wait;
      r_run_cnt  <= w_run_cnt;
      r_status   <= w_status;
      r_data_in  <= w_data_in;
      r_addr     <= w_addr;
      r_rx_ready <= w_rx_ready;
      r_tx_valid <= w_tx_valid;
      r_tx_data  <= w_tx_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign status       = r_status;
  assign data_in      = r_data_in;
  assign data_addr_in = r_addr;
  assign rx_ready     = r_rx_ready;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_mem_run_sequencer.sv
// Bench for mem_run_sequencer: scoreboarded load writes and readback bytes over one aborted
// and one complete job, with a latency-accurate memory model returning the address LSB.
module tb_mem_run_sequencer;

  localparam logic [15:0] LB = 16'h0010;
  localparam logic [15:0] LC = 16'd4;
  localparam logic [15:0] RB = 16'hFFFF;
  localparam logic [15:0] RC = 16'd3;
  localparam int unsigned RL = 2;
  localparam int unsigned MR = 2;

  logic        clk, rst, start, rx_valid, rx_ready, end_process;
  logic [7:0]  rx_data, dm_out, tx_data, data_in;
  logic        tx_valid, tx_ready, busy, done;
  logic [1:0]  status;
  logic [15:0] data_addr_in;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_wr[$];
  logic [23:0] exp_rd[$];

  mem_run_sequencer #(
    .LOAD_BASE (LB),
    .LOAD_COUNT(LC),
    .READ_BASE (RB),
    .READ_COUNT(RC),
    .RD_LAT    (RL),
    .MIN_RUN   (MR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .end_process (end_process),
    .dm_out      (dm_out),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .status      (status),
    .data_in     (data_in),
    .data_addr_in(data_addr_in),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage memory pipeline: data valid RD_LAT=2 cycles after the address changes
  logic [7:0] mem_p0, mem_p1;
  always @(posedge clk) begin
    mem_p0 <= data_addr_in[7:0];
    mem_p1 <= mem_p0;
  end
  assign dm_out = mem_p1;

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    end_process = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({status, busy, done, rx_ready, tx_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {status, busy, done, rx_ready, tx_valid});
    end
    total++;
    if ({data_addr_in, data_in, tx_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=00000000", {data_addr_in, data_in, tx_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    logic [23:0] e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, rx_ready} !== 2'b11) begin
      bad++;
      $display("FAIL midload_enter got=%b want=11", {busy, rx_ready});
    end
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h10 + i);
      exp_wr.push_back({LB + 16'(i), rx_data});
      @(negedge clk);
      e = exp_wr.pop_front();
      total++;
      if ({status, data_addr_in, data_in} !== {2'b10, e}) begin
        bad++;
        $display("FAIL midload_write%0d got=%b_%h want=10_%h", i, status,
                 {data_addr_in, data_in}, e);
      end
    end
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({status, busy, rx_ready} !== 4'b0) begin
      bad++;
      $display("FAIL midload_abort got=%b want=0000", {status, busy, rx_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_gapped;
    logic [7:0]  bytes [4];
    logic [23:0] e;
    int          n_wr;
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    n_wr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1'b1;
      rx_data  = bytes[k];
      exp_wr.push_back({LB + 16'(k), bytes[k]});
      if (k == 3) end_process = 1'b1;
      @(negedge clk);
      if (status == 2'b10) n_wr++;
      e = exp_wr.pop_front();
      total++;
      if ({status, data_addr_in, data_in} !== {2'b10, e}) begin
        bad++;
        $display("FAIL load_write%0d got=%b_%h want=10_%h", k, status,
                 {data_addr_in, data_in}, e);
      end
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      if (k == 3) begin
        total++;
        if (rx_ready !== 1'b0) begin
          bad++;
          $display("FAIL load_ready_drop got=%b want=0", rx_ready);
        end
      end else begin
        @(negedge clk);
        if (status == 2'b10) n_wr++;
        total++;
        if ({status, rx_ready} !== 3'b001) begin
          bad++;
          $display("FAIL load_gap%0d got=%b want=001", k, {status, rx_ready});
        end
      end
    end
    total++;
    if (n_wr != 4) begin
      bad++;
      $display("FAIL load_write_count got=%0d want=4", n_wr);
    end
  endtask

  task automatic test_run_min;
    int rc = 0;
    int n  = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      start = (n == 1);
      if (status == 2'b01 && rx_ready == 1'b0) rc++;
      else break;
    end
    start = 1'b0;
    end_process = 1'b0;
    total++;
    if (rc < int'(MR)) begin
      bad++;
      $display("FAIL run_min_cycles got=%0d want>=%0d", rc, MR);
    end
    total++;
    if ({status, data_addr_in} !== {2'b11, RB}) begin
      bad++;
      $display("FAIL run_exit got=%b_%h want=11_%h", status, data_addr_in, RB);
    end
  endtask

  task automatic test_readback_stall;
    logic [23:0] e;
    logic [15:0] a;
    int n = 0, stall = 0, rb = 0;
    int t_first [3];
    logic prev_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = RB + 16'(i);
      exp_rd.push_back({a, a[7:0]});
      t_first[i] = 0;
    end
    tx_ready = 1'b1;
    while (exp_rd.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (tx_valid) begin
        if (!prev_v) t_first[rb] = n;
        if (rb == 1 && stall < 5) begin
          tx_ready = 1'b0;
          stall++;
          total++;
          if ({status, data_addr_in, tx_data} !== {2'b11, exp_rd[0]}) begin
            bad++;
            $display("FAIL rd_stall_hold%0d got=%b_%h want=11_%h", stall, status,
                     {data_addr_in, tx_data}, exp_rd[0]);
          end
        end else begin
          tx_ready = 1'b1;
          e = exp_rd.pop_front();
          total++;
          if ({data_addr_in, tx_data} !== e) begin
            bad++;
            $display("FAIL rd_byte%0d got=%h want=%h", rb, {data_addr_in, tx_data}, e);
          end
          rb++;
        end
      end else begin
        tx_ready = 1'b1;
      end
      prev_v = tx_valid;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL rd_timeout got=%0d bytes want=3", rb);
    end
    total++;
    if (t_first[1] - t_first[0] != int'(RL) + 2) begin
      bad++;
      $display("FAIL rd_throughput got=%0d want=%0d", t_first[1] - t_first[0], RL + 2);
    end
  endtask

  task automatic test_done;
    @(negedge clk);
    total++;
    if ({done, busy, status} !== 4'b1100) begin
      bad++;
      $display("FAIL done_pulse got=%b want=1100", {done, busy, status});
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL done_clear got=%b want=00", {done, busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({done, busy, status, rx_ready} !== 5'b0) begin
        bad++;
        $display("FAIL idle_stay%0d got=%b want=00000", i, {done, busy, status, rx_ready});
      end
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_load_gapped();
    test_run_min();
    test_readback_stall();
    test_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
